// File: rtl/ccip_rd_stream_pkg.sv
// Shared types and constants for the CCI-P bulk read stream engine.
// Holds the engine state enum, the address/tag/data widths and the channel 0
// request encodings. The encodings are mirrored from ccip_if_pkg so this
// slice compiles without the platform package.
package ccip_rd_stream_pkg;

    localparam int unsigned RD_STREAM_ADDR_W = 42;
    localparam int unsigned RD_STREAM_TAG_W  = 16;
    localparam int unsigned RD_STREAM_DATA_W = 512;

    // c0 request header fields: eREQ_RDLINE_I, eVC_VA, eCL_LEN_1
    localparam logic [3:0] RD_STREAM_REQ_RDLINE_I = 4'h0;
    localparam logic [1:0] RD_STREAM_VC_VA        = 2'h0;
    localparam logic [1:0] RD_STREAM_CL_LEN_1     = 2'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_rd_stream_state;

endpackage

// File: rtl/ccip_rd_stream_credit.sv
// Outstanding-read counter for the read stream engine.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   inc_i       - a read request is issued this cycle
//   dec_i       - a read response is accepted this cycle
//   full_o      - registered: count == MAX_OUTSTANDING
//   empty_o     - registered: count == 0
// The caller never raises inc_i while full_o or dec_i while empty_o.
module ccip_rd_stream_credit #(
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CRD_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CRD_W-1:0] count_q;
    logic [CRD_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;

    // Simultaneous issue and response leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CRD_W'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CRD_W'(1);
        end
    end

    // Flags are derived from the next count so they track count_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CRD_W'(MAX_OUTSTANDING));
            empty_q <= (count_d == '0);
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ccip_rd_stream_engine.sv
// Bulk CCI-P channel 0 read engine.
// Reads num_lines consecutive cache lines starting at base_addr, one line per
// request, throttled by c0_tx_alm_full and MAX_OUTSTANDING (1..1024), and
// forwards every response tagged with its line index.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start, base_addr, num_lines - run request (sampled when idle)
//   busy, done, err_stray       - run status
//   c0_tx_*                     - read request out / almost-full in
//   c0_rx_*                     - read response in
//   rd_valid, rd_idx, rd_data   - forwarded response (no backpressure)
//   lines_req, lines_rsp        - per-run request/response counts
// All outputs are registered.
module ccip_rd_stream_engine
    import ccip_rd_stream_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [RD_STREAM_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]            num_lines,
    output logic                        busy,
    output logic                        done,
    output logic                        err_stray,
    output logic                        c0_tx_valid,
    output logic [RD_STREAM_ADDR_W-1:0] c0_tx_addr,
    output logic [RD_STREAM_TAG_W-1:0]  c0_tx_mdata,
    input  logic                        c0_tx_alm_full,
    input  logic                        c0_rx_rd_valid,
    input  logic [RD_STREAM_TAG_W-1:0]  c0_rx_mdata,
    input  logic [RD_STREAM_DATA_W-1:0] c0_rx_data,
    output logic                        rd_valid,
    output logic [RD_STREAM_TAG_W-1:0]  rd_idx,
    output logic [RD_STREAM_DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]            lines_req,
    output logic [CNT_W-1:0]            lines_rsp
);

    t_rd_stream_state            state_q,     state_d;
    logic [RD_STREAM_ADDR_W-1:0] base_q,      base_d;
    logic [CNT_W-1:0]            num_q,       num_d;
    logic [CNT_W-1:0]            lines_req_q, lines_req_d;
    logic [CNT_W-1:0]            lines_rsp_q, lines_rsp_d;
    logic                        busy_q,      busy_d;
    logic                        done_q,      done_d;
    logic                        err_q,       err_d;
    logic                        tx_valid_q,  tx_valid_d;
    logic [RD_STREAM_ADDR_W-1:0] tx_addr_q,   tx_addr_d;
    logic [RD_STREAM_TAG_W-1:0]  tx_mdata_q,  tx_mdata_d;
    logic                        rd_valid_q,  rd_valid_d;
    logic [RD_STREAM_TAG_W-1:0]  rd_idx_q,    rd_idx_d;
    logic [RD_STREAM_DATA_W-1:0] rd_data_q,   rd_data_d;

    logic                        crd_full;
    logic                        crd_empty;
    logic                        idle_start_c;
    logic                        issue_c;
    logic                        rsp_acc_c;
    logic                        rsp_stray_c;
    logic [RD_STREAM_ADDR_W-1:0] cur_base_c;
    logic [CNT_W-1:0]            cur_num_c;
    logic [CNT_W-1:0]            cur_req_c;
    logic [CNT_W-1:0]            req_next_c;

    ccip_rd_stream_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (issue_c),
        .dec_i   (rsp_acc_c),
        .full_o  (crd_full),
        .empty_o (crd_empty)
    );

    // The first request goes out on the accepting edge itself, so the run
    // parameters are taken straight from the inputs while idle.
    always_comb begin
        idle_start_c = (state_q == ST_IDLE) && start;
        cur_base_c   = idle_start_c ? base_addr : base_q;
        cur_num_c    = idle_start_c ? num_lines : num_q;
        cur_req_c    = idle_start_c ? '0 : lines_req_q;
        req_next_c   = cur_req_c + CNT_W'(1);
        issue_c      = ((state_q == ST_ISSUE) || (idle_start_c && (num_lines != '0)))
                       && !c0_tx_alm_full && !crd_full;
        // Responses only count while a run is active and something is in flight.
        rsp_acc_c    = c0_rx_rd_valid && !crd_empty
                       && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
        rsp_stray_c  = c0_rx_rd_valid && !rsp_acc_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        lines_req_d = lines_req_q;
        lines_rsp_d = lines_rsp_q;
        err_d       = err_q;
        tx_valid_d  = issue_c;
        tx_addr_d   = tx_addr_q;
        tx_mdata_d  = tx_mdata_q;
        rd_valid_d  = rsp_acc_c;
        rd_idx_d    = rd_idx_q;
        rd_data_d   = rd_data_q;

        if (rsp_acc_c) begin
            lines_rsp_d = lines_rsp_q + CNT_W'(1);
            rd_idx_d    = c0_rx_mdata;
            rd_data_d   = c0_rx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    num_d       = num_lines;
                    lines_req_d = '0;
                    lines_rsp_d = '0;
                    err_d       = 1'b0;
                    state_d     = (num_lines == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
            end
            ST_DRAIN: begin
                if (lines_rsp_d == num_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_c) begin
            tx_addr_d   = cur_base_c + RD_STREAM_ADDR_W'(cur_req_c);
            tx_mdata_d  = RD_STREAM_TAG_W'(cur_req_c);
            lines_req_d = req_next_c;
            if (req_next_c == cur_num_c) begin
                state_d = ST_DRAIN;
            end
        end

        // Set after the start-clear so a stray beat on the start cycle still shows.
        if (rsp_stray_c) begin
            err_d = 1'b1;
        end

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            lines_req_q <= '0;
            lines_rsp_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            lines_req_q <= lines_req_d;
            lines_rsp_q <= lines_rsp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_mdata_q  <= tx_mdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_stray   = err_q;
    assign c0_tx_valid = tx_valid_q;
    assign c0_tx_addr  = tx_addr_q;
    assign c0_tx_mdata = tx_mdata_q;
    assign rd_valid    = rd_valid_q;
    assign rd_idx      = rd_idx_q;
    assign rd_data     = rd_data_q;
    assign lines_req   = lines_req_q;
    assign lines_rsp   = lines_rsp_q;

endmodule

// File: tb/tb_ccip_rd_stream_engine.sv
// Directed bench for ccip_rd_stream_engine: instance a uses the default
// credit depth, instance b uses MAX_OUTSTANDING = 2 for the throttling run.
module tb_ccip_rd_stream_engine;
    import ccip_rd_stream_pkg::*;

    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic                        start_a, start_b;
    logic [RD_STREAM_ADDR_W-1:0] base_a,  base_b;
    logic [CNT_W-1:0]            num_a,   num_b;
    logic                        alm_a,   alm_b;
    logic                        rxv_a,   rxv_b;
    logic [RD_STREAM_TAG_W-1:0]  rxm_a,   rxm_b;
    logic [RD_STREAM_DATA_W-1:0] rxd_a,   rxd_b;
    logic                        busy_a,  busy_b;
    logic                        done_a,  done_b;
    logic                        err_a,   err_b;
    logic                        txv_a,   txv_b;
    logic [RD_STREAM_ADDR_W-1:0] txaddr_a, txaddr_b;
    logic [RD_STREAM_TAG_W-1:0]  txmd_a,  txmd_b;
    logic                        rdv_a,   rdv_b;
    logic [RD_STREAM_TAG_W-1:0]  rdidx_a, rdidx_b;
    logic [RD_STREAM_DATA_W-1:0] rddata_a, rddata_b;
    logic [CNT_W-1:0]            req_a,   req_b;
    logic [CNT_W-1:0]            rsp_a,   rsp_b;

    ccip_rd_stream_engine #(.MAX_OUTSTANDING(64), .CNT_W(CNT_W)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .num_lines(num_a),
        .busy(busy_a), .done(done_a), .err_stray(err_a),
        .c0_tx_valid(txv_a), .c0_tx_addr(txaddr_a), .c0_tx_mdata(txmd_a), .c0_tx_alm_full(alm_a),
        .c0_rx_rd_valid(rxv_a), .c0_rx_mdata(rxm_a), .c0_rx_data(rxd_a),
        .rd_valid(rdv_a), .rd_idx(rdidx_a), .rd_data(rddata_a),
        .lines_req(req_a), .lines_rsp(rsp_a)
    );

    ccip_rd_stream_engine #(.MAX_OUTSTANDING(2), .CNT_W(CNT_W)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .num_lines(num_b),
        .busy(busy_b), .done(done_b), .err_stray(err_b),
        .c0_tx_valid(txv_b), .c0_tx_addr(txaddr_b), .c0_tx_mdata(txmd_b), .c0_tx_alm_full(alm_b),
        .c0_rx_rd_valid(rxv_b), .c0_rx_mdata(rxm_b), .c0_rx_data(rxd_b),
        .rd_valid(rdv_b), .rd_idx(rdidx_b), .rd_data(rddata_b),
        .lines_req(req_b), .lines_rsp(rsp_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pat(input logic [15:0] i);
        pat = {8{48'hC0DE_5EED_0000, i}};
    endfunction

    // One response beat on instance a, consumed at the next edge.
    task automatic resp_a(input logic [15:0] tag);
        rxv_a = 1'b1;
        rxm_a = tag;
        rxd_a = pat(tag);
        tick();
        rxv_a = 1'b0;
    endtask

    logic [511:0]  exp_d;
    int            due_q[$];
    logic [15:0]   dtag_q[$];
    int            n_iss, n_rsp, max_infl, alm_viol, addr_err, beats, done_seen;
    logic          alm_prev, rsp_now;

    initial begin
        reset = 1'b1;
        start_a = 0; base_a = '0; num_a = '0; alm_a = 0; rxv_a = 0; rxm_a = '0; rxd_a = '0;
        start_b = 0; base_b = '0; num_b = '0; alm_b = 0; rxv_b = 0; rxm_b = '0; rxd_b = '0;
        tick();
        tick();

        // Reset values
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_txv", txv_a, 0);
        chk("rst_rdv", rdv_a, 0);
        chk("rst_req", req_a, 0);
        chk("rst_rsp", rsp_a, 0);
        chk("rst_addr", txaddr_a, 0);
        chk("rst_mdata", txmd_a, 0);
        chk("rst_idx", rdidx_a, 0);
        chk("rst_data", rddata_a[63:0], 0);
        reset = 1'b0;
        tick();

        // Basic 4-line run, in-order responses
        base_a = 42'h1000; num_a = 4; start_a = 1; tick(); start_a = 0;
        for (int i = 0; i < 4; i++) begin
            chk("basic_txv", txv_a, 1);
            chk("basic_addr", txaddr_a, 64'h1000 + 64'(i));
            chk("basic_tag", txmd_a, 64'(i));
            chk("basic_busy", busy_a, 1);
            tick();
        end
        chk("basic_txv_end", txv_a, 0);
        chk("basic_req", req_a, 4);
        for (int i = 0; i < 4; i++) begin
            resp_a(16'(i));
            exp_d = pat(16'(i));
            chk("basic_rdv", rdv_a, 1);
            chk("basic_idx", rdidx_a, 64'(i));
            chk("basic_data", rddata_a[63:0], exp_d[63:0]);
            chk("basic_done", done_a, (i == 3) ? 64'd1 : 64'd0);
        end
        chk("basic_busy_done", busy_a, 0);
        chk("basic_req_final", req_a, 4);
        chk("basic_rsp_final", rsp_a, 4);
        chk("basic_err", err_a, 0);
        tick();
        chk("basic_done_1cyc", done_a, 0);

        // Zero-line run
        num_a = 0; start_a = 1; tick(); start_a = 0;
        chk("zero_done", done_a, 1);
        chk("zero_busy", busy_a, 0);
        chk("zero_txv", txv_a, 0);
        chk("zero_req", req_a, 0);
        tick();
        chk("zero_done_1cyc", done_a, 0);
        chk("zero_txv2", txv_a, 0);

        // Address wrap, plus an almost-full hold between the two issues
        base_a = 42'h3FF_FFFF_FFFF; num_a = 2; start_a = 1; tick(); start_a = 0;
        chk("wrap_addr0", txaddr_a, 64'h3FF_FFFF_FFFF);
        alm_a = 1; tick(); alm_a = 0;
        chk("almfull_hold", txv_a, 0);
        tick();
        chk("wrap_txv1", txv_a, 1);
        chk("wrap_addr1", txaddr_a, 0);
        chk("wrap_tag1", txmd_a, 1);
        tick();
        resp_a(16'd0);
        resp_a(16'd1);
        chk("wrap_done", done_a, 1);
        tick();

        // Response and issue in the same cycle
        base_a = 42'h50; num_a = 2; start_a = 1; tick(); start_a = 0;
        chk("same_cnt_before", u_a.u_credit.count_q, 1);
        rxv_a = 1; rxm_a = 16'd0; rxd_a = pat(16'd0); tick(); rxv_a = 0;
        chk("same_txv", txv_a, 1);
        chk("same_addr", txaddr_a, 64'h51);
        chk("same_rdv", rdv_a, 1);
        chk("same_cnt", u_a.u_credit.count_q, 1);
        resp_a(16'd1);
        chk("same_done", done_a, 1);
        chk("same_cnt_end", u_a.u_credit.count_q, 0);
        tick();

        // Out-of-order responses, with a start pulse while busy
        base_a = 42'h2000; num_a = 3; start_a = 1; tick(); start_a = 0;
        chk("ooo_addr0", txaddr_a, 64'h2000);
        base_a = 42'hDEAD; num_a = 9; start_a = 1; tick(); start_a = 0;
        chk("busy_start_addr", txaddr_a, 64'h2001);
        chk("busy_start_tag", txmd_a, 1);
        chk("busy_start_req", req_a, 2);
        chk("busy_start_busy", busy_a, 1);
        tick();
        chk("ooo_addr2", txaddr_a, 64'h2002);
        chk("ooo_req3", req_a, 3);
        tick();
        chk("ooo_txv_end", txv_a, 0);
        begin
            logic [15:0] order [3];
            order[0] = 16'd2; order[1] = 16'd0; order[2] = 16'd1;
            for (int i = 0; i < 3; i++) begin
                resp_a(order[i]);
                exp_d = pat(order[i]);
                chk("ooo_idx", rdidx_a, 64'(order[i]));
                chk("ooo_data", rddata_a[511:448], exp_d[511:448]);
                chk("ooo_rsp", rsp_a, 64'(i + 1));
                chk("ooo_done", done_a, (i == 2) ? 64'd1 : 64'd0);
            end
        end
        chk("ooo_req_final", req_a, 3);
        tick();

        // Reset after 3 of 8 issued, then stragglers
        base_a = 42'h100; num_a = 8; start_a = 1; tick(); start_a = 0;
        tick();
        tick();
        chk("mid_req3", req_a, 3);
        reset = 1; tick(); reset = 0;
        chk("mid_busy", busy_a, 0);
        chk("mid_txv", txv_a, 0);
        chk("mid_req", req_a, 0);
        for (int i = 0; i < 3; i++) begin
            resp_a(16'(i));
            chk("mid_no_rdv", rdv_a, 0);
        end
        chk("mid_err", err_a, 1);
        base_a = 42'h10; num_a = 1; start_a = 1; tick(); start_a = 0;
        chk("restart_err_clr", err_a, 0);
        chk("restart_txv", txv_a, 1);
        chk("restart_addr", txaddr_a, 64'h10);
        resp_a(16'd0);
        chk("restart_rdv", rdv_a, 1);
        chk("restart_done", done_a, 1);
        chk("restart_err", err_a, 0);
        tick();

        // Throttled run on instance b: 2 credits, 10-cycle response delay
        n_iss = 0; n_rsp = 0; max_infl = 0; alm_viol = 0; addr_err = 0; beats = 0; done_seen = 0;
        for (int c = 0; c < 100 && done_seen == 0; c++) begin
            start_b = (c == 0);
            base_b  = 42'h8000;
            num_b   = 6;
            alm_b   = (c >= 3 && c <= 7);
            rxv_b   = 0;
            if (due_q.size() > 0 && due_q[0] == c) begin
                rxv_b = 1;
                rxm_b = dtag_q[0];
                rxd_b = pat(dtag_q[0]);
                void'(due_q.pop_front());
                void'(dtag_q.pop_front());
            end
            alm_prev = alm_b;
            rsp_now  = rxv_b;
            tick();
            if (rsp_now) n_rsp++;
            if (txv_b) begin
                if (alm_prev) alm_viol++;
                if (txaddr_b != 42'h8000 + 42'(n_iss)) addr_err++;
                due_q.push_back(c + 10);
                dtag_q.push_back(txmd_b);
                n_iss++;
            end
            if (rdv_b) beats++;
            if (n_iss - n_rsp > max_infl) max_infl = n_iss - n_rsp;
            if (done_b) done_seen = 1;
        end
        start_b = 0; alm_b = 0; rxv_b = 0;
        chk("bp_max_inflight", 64'(max_infl), 2);
        chk("bp_almfull_issue", 64'(alm_viol), 0);
        chk("bp_addr_seq", 64'(addr_err), 0);
        chk("bp_issued", 64'(n_iss), 6);
        chk("bp_beats", 64'(beats), 6);
        chk("bp_done", 64'(done_seen), 1);
        chk("bp_lines_rsp", rsp_b, 6);
        chk("bp_err", err_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
